// File: rtl/rs_ex_muldiv_pkg.sv
// Shared opcode numbering and state types for the RV32M execute unit.
// The M-extension opcodes sit directly after OPNUM_ANDI in the opcode space.
package rs_ex_muldiv_pkg;

  localparam int OPNUM_WIDTH = 6;
  typedef logic [OPNUM_WIDTH-1:0] opnum_t;

  localparam opnum_t OPNUM_ANDI   = 6'd37;
  localparam opnum_t OPNUM_MUL    = 6'd38;
  localparam opnum_t OPNUM_MULH   = 6'd39;
  localparam opnum_t OPNUM_MULHSU = 6'd40;
  localparam opnum_t OPNUM_MULHU  = 6'd41;
  localparam opnum_t OPNUM_DIV    = 6'd42;
  localparam opnum_t OPNUM_DIVU   = 6'd43;
  localparam opnum_t OPNUM_REM    = 6'd44;
  localparam opnum_t OPNUM_REMU   = 6'd45;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_t;

  function automatic logic is_m_op(input opnum_t op);
    return (op >= OPNUM_MUL) && (op <= OPNUM_REMU);
  endfunction

  function automatic logic is_mul_op(input opnum_t op);
    return (op >= OPNUM_MUL) && (op <= OPNUM_MULHU);
  endfunction

endpackage

// File: rtl/rs_ex_muldiv_ex_divider.sv
// Radix-2 restoring divider with sign fix-up; divide-by-zero and overflow bypass the loop.
// Latency: XLEN+1 cycles from start to done, 1 cycle for the special cases.
// Backpressure: holds DONE until ack; busy only while iterating.
module ex_divider
  import rs_ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_rem,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic [TAG_W-1:0] tag,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] result_tag
);

  localparam int CW = $clog2(XLEN) + 1;

  div_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [XLEN-1:0]  quo, rem, dsr;
  logic             neg_q, neg_r, want_rem;
  logic [TAG_W-1:0] tag_q;

  logic             dvd_neg, dsr_neg, div_zero, ovf, special, take, load;
  logic [XLEN-1:0]  dvd_mag, dsr_mag;
  logic [XLEN:0]    shifted, diff;

  always_comb begin
    dvd_neg  = is_signed && dividend[XLEN-1];
    dsr_neg  = is_signed && divisor[XLEN-1];
    dvd_mag  = dvd_neg ? -dividend : dividend;
    dsr_mag  = dsr_neg ? -divisor : divisor;
    div_zero = (divisor == '0);
    ovf      = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    special  = div_zero || ovf;
    load     = start && !flush && (state != DIV_CALC);
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, dsr};
    take     = !diff[XLEN];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start) state_nxt = special ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt == CW'(XLEN - 1)) state_nxt = DIV_DONE;
      DIV_DONE: if (ack) state_nxt = start ? (special ? DIV_DONE : DIV_CALC) : DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
    if (flush) state_nxt = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dsr      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
      tag_q    <= '0;
    end else if (en) begin
      state <= state_nxt;
      if (load) begin
        cnt      <= '0;
        dsr      <= dsr_mag;
        tag_q    <= tag;
        want_rem <= is_rem;
        // Special cases store final values, so fix-up must stay disabled.
        if (div_zero) begin
          quo   <= '1;
          rem   <= dividend;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (ovf) begin
          quo   <= dividend;
          rem   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          quo   <= dvd_mag;
          rem   <= '0;
          neg_q <= dvd_neg ^ dsr_neg;
          neg_r <= dvd_neg;
        end
      end else if (state == DIV_CALC) begin
        cnt <= cnt + CW'(1);
        rem <= take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], take};
      end
    end
  end

  always_comb begin
    busy       = (state == DIV_CALC);
    done       = (state == DIV_DONE);
    result     = want_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
    result_tag = tag_q;
  end

endmodule

// File: rtl/rs_ex_muldiv.sv
// RV32M execute unit: pipelined multiplier plus iterative divider sharing one result bus.
// Latency: MUL_STAGES for multiplies, XLEN+1 for divides (1 for divide special cases).
// Backpressure: in_ready low while dividing or while a divide result waits behind a multiply.
module rs_ex_muldiv
  import rs_ex_muldiv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ROB_ID_WIDTH = 4,
  parameter int MUL_STAGES   = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rollback_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPNUM_WIDTH-1:0]  in_opnum,
  input  logic [XLEN-1:0]         in_v1,
  input  logic [XLEN-1:0]         in_v2,
  input  logic [ROB_ID_WIDTH-1:0] in_rob_id,
  output logic                    out_valid,
  output logic [XLEN-1:0]         out_data,
  output logic [ROB_ID_WIDTH-1:0] out_rob_id
);

  localparam int PW = 2 * XLEN;

  logic                    accept, mul_acc, div_acc, a_sgn, b_sgn;
  logic                    div_signed, div_rem;
  logic [PW-1:0]           a_w, b_w, prod;
  logic                    mul_vld [MUL_STAGES];
  logic                    mul_hi  [MUL_STAGES];
  logic [PW-1:0]           mul_prod[MUL_STAGES];
  logic [ROB_ID_WIDTH-1:0] mul_tag [MUL_STAGES];
  logic                    tail_vld;
  logic [XLEN-1:0]         tail_dat;
  logic                    div_busy, div_done, div_hold, div_ack;
  logic [XLEN-1:0]         div_res;
  logic [ROB_ID_WIDTH-1:0] div_tag;

  always_comb begin
    accept     = in_valid && in_ready && rdy_in && !rollback_in && is_m_op(in_opnum);
    mul_acc    = accept && is_mul_op(in_opnum);
    div_acc    = accept && !is_mul_op(in_opnum);
    a_sgn      = (in_opnum == OPNUM_MULH) || (in_opnum == OPNUM_MULHSU);
    b_sgn      = (in_opnum == OPNUM_MULH);
    div_signed = (in_opnum == OPNUM_DIV) || (in_opnum == OPNUM_REM);
    div_rem    = (in_opnum == OPNUM_REM) || (in_opnum == OPNUM_REMU);
    // Extending to the full product width keeps the low 2*XLEN bits exact for every sign mix.
    a_w        = {{XLEN{a_sgn & in_v1[XLEN-1]}}, in_v1};
    b_w        = {{XLEN{b_sgn & in_v2[XLEN-1]}}, in_v2};
    prod       = a_w * b_w;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        mul_vld[i]  <= 1'b0;
        mul_hi[i]   <= 1'b0;
        mul_prod[i] <= '0;
        mul_tag[i]  <= '0;
      end
    end else if (rdy_in) begin
      mul_vld[0]  <= mul_acc;
      mul_hi[0]   <= (in_opnum != OPNUM_MUL);
      mul_prod[0] <= prod;
      mul_tag[0]  <= in_rob_id;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mul_vld[i]  <= mul_vld[i-1];
        mul_hi[i]   <= mul_hi[i-1];
        mul_prod[i] <= mul_prod[i-1];
        mul_tag[i]  <= mul_tag[i-1];
      end
      if (rollback_in) begin
        for (int i = 0; i < MUL_STAGES; i++) mul_vld[i] <= 1'b0;
      end
    end
  end

  ex_divider #(
    .XLEN  (XLEN),
    .TAG_W (ROB_ID_WIDTH)
  ) u_div (
    .clk        (clk_in),
    .rst        (rst_in),
    .en         (rdy_in),
    .flush      (rollback_in),
    .start      (div_acc),
    .is_signed  (div_signed),
    .is_rem     (div_rem),
    .dividend   (in_v1),
    .divisor    (in_v2),
    .tag        (in_rob_id),
    .ack        (div_ack),
    .busy       (div_busy),
    .done       (div_done),
    .result     (div_res),
    .result_tag (div_tag)
  );

  // Multiply tail wins the result bus; a finished divide waits one more cycle.
  always_comb begin
    tail_vld   = mul_vld[MUL_STAGES-1];
    tail_dat   = mul_hi[MUL_STAGES-1] ? mul_prod[MUL_STAGES-1][PW-1:XLEN]
                                      : mul_prod[MUL_STAGES-1][XLEN-1:0];
    div_hold   = div_done && tail_vld && !rollback_in;
    div_ack    = div_done && !tail_vld;
    in_ready   = !div_busy && !div_hold;
    out_valid  = !rollback_in && (tail_vld || div_done);
    out_data   = tail_vld ? tail_dat : (div_done ? div_res : '0);
    out_rob_id = tail_vld ? mul_tag[MUL_STAGES-1] : (div_done ? div_tag : '0);
  end

endmodule

// File: tb/tb_rs_ex_muldiv.sv
// Directed self-checking bench for rs_ex_muldiv: vector table plus multi-cycle corner sequences.
module tb_rs_ex_muldiv;
  import rs_ex_muldiv_pkg::*;

  localparam int MS = 3;
  localparam int NV = 20;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, in_valid, in_ready, out_valid;
  opnum_t      in_opnum;
  logic [31:0] in_v1, in_v2, out_data;
  logic [3:0]  in_rob_id, out_rob_id;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    opnum_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[NV];

  always #5 clk = ~clk;

  rs_ex_muldiv #(.XLEN(32), .ROB_ID_WIDTH(4), .MUL_STAGES(MS)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .rdy_in      (rdy),
    .rollback_in (rollback),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opnum    (in_opnum),
    .in_v1       (in_v1),
    .in_v2       (in_v2),
    .in_rob_id   (in_rob_id),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_rob_id  (out_rob_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input opnum_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    in_valid  = 1'b1;
    in_opnum  = op;
    in_v1     = a;
    in_v2     = b;
    in_rob_id = tag;
  endtask

  // Cycle k=1 is the cycle right after the accepting edge.
  task automatic wait_out(input int budget, input logic exp_rdy, output int lat, output int bad_rdy);
    lat = -1;
    bad_rdy = 0;
    for (int k = 1; k <= budget; k++) begin
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (in_ready !== exp_rdy) bad_rdy++;
      tick();
    end
  endtask

  task automatic count_out(input int n, output int hits);
    hits = 0;
    for (int k = 0; k < n; k++) begin
      if (out_valid !== 1'b0) hits++;
      tick();
    end
  endtask

  initial begin
    int lat, bad, hits, total;

    vecs[0]  = '{OPNUM_MULH,   32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, MS};
    vecs[1]  = '{OPNUM_MUL,    32'h00010000, 32'h00010000, 32'h00000000, MS};
    vecs[2]  = '{OPNUM_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, MS};
    vecs[3]  = '{OPNUM_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MS};
    vecs[4]  = '{OPNUM_MULHU,  32'hFFFFFFFF, 32'd2,        32'h00000001, MS};
    vecs[5]  = '{OPNUM_MUL,    32'd7,        32'd6,        32'h0000002A, MS};
    vecs[6]  = '{OPNUM_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MS};
    vecs[7]  = '{OPNUM_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MS};
    vecs[8]  = '{OPNUM_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[9]  = '{OPNUM_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[10] = '{OPNUM_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[11] = '{OPNUM_REMU,   32'd5,        32'd0,        32'h00000005, 1};
    vecs[12] = '{OPNUM_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[13] = '{OPNUM_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[14] = '{OPNUM_DIVU,   32'd100,      32'd7,        32'd14,       33};
    vecs[15] = '{OPNUM_REMU,   32'd100,      32'd7,        32'd2,        33};
    vecs[16] = '{OPNUM_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[17] = '{OPNUM_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 33};
    vecs[18] = '{OPNUM_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1};
    vecs[19] = '{OPNUM_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0;
    in_opnum = OPNUM_ANDI; in_v1 = '0; in_v2 = '0; in_rob_id = '0;
    tick();
    tick();
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_rob_id", {28'b0, out_rob_id}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      check($sformatf("vec%0d_issue_ready", i), {31'b0, in_ready}, 32'd1);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i));
      tick();
      in_valid = 1'b0;
      wait_out(60, (vecs[i].lat == MS), lat, bad);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      check($sformatf("vec%0d_rob_id", i), {28'b0, out_rob_id}, {28'b0, 4'(i)});
      check($sformatf("vec%0d_ready_at_out", i), {31'b0, in_ready}, 32'd1);
      check($sformatf("vec%0d_ready_while_waiting", i), 32'(bad), 32'd0);
      tick();
      check($sformatf("vec%0d_single_broadcast", i), {31'b0, out_valid}, 32'd0);
    end

    // Back-to-back multiplies on consecutive cycles.
    drive(OPNUM_MUL, 32'h00010000, 32'h00010000, 4'd1);
    tick();
    drive(OPNUM_MULHU, 32'h00010000, 32'h00010000, 4'd2);
    tick();
    in_valid = 1'b0;
    tick();
    check("b2b_first_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_first_data", out_data, 32'h0);
    check("b2b_first_tag", {28'b0, out_rob_id}, 32'd1);
    tick();
    check("b2b_second_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_second_data", out_data, 32'h1);
    check("b2b_second_tag", {28'b0, out_rob_id}, 32'd2);
    tick();
    check("b2b_drained", {31'b0, out_valid}, 32'd0);

    // Special-case divide finishing on the same cycle as a multiply tail.
    drive(OPNUM_MUL, 32'd3, 32'd4, 4'd5);
    tick();
    in_valid = 1'b0;
    tick();
    drive(OPNUM_DIVU, 32'd5, 32'd0, 4'd6);
    tick();
    in_valid = 1'b0;
    check("coll_mul_valid", {31'b0, out_valid}, 32'd1);
    check("coll_mul_data", out_data, 32'd12);
    check("coll_mul_tag", {28'b0, out_rob_id}, 32'd5);
    check("coll_hold_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("coll_div_valid", {31'b0, out_valid}, 32'd1);
    check("coll_div_data", out_data, 32'hFFFFFFFF);
    check("coll_div_tag", {28'b0, out_rob_id}, 32'd6);
    check("coll_div_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("coll_drained", {31'b0, out_valid}, 32'd0);

    // Rollback with two multiplies in flight and the divider iterating.
    drive(OPNUM_MUL, 32'd3, 32'd5, 4'd1);
    tick();
    drive(OPNUM_MUL, 32'd3, 32'd6, 4'd2);
    tick();
    drive(OPNUM_DIVU, 32'd100, 32'd7, 4'd3);
    tick();
    in_valid = 1'b0;
    check("rb_pre_tail_valid", {31'b0, out_valid}, 32'd1);
    check("rb_pre_div_busy", {31'b0, in_ready}, 32'd0);
    rollback = 1'b1;
    #1;
    check("rb_suppress", {31'b0, out_valid}, 32'd0);
    tick();
    rollback = 1'b0;
    check("rb_ready_next", {31'b0, in_ready}, 32'd1);
    count_out(40, hits);
    check("rb_no_output_40", 32'(hits), 32'd0);

    // Freeze with rdy_in low for 5 cycles mid-divide.
    drive(OPNUM_DIV, 32'hFFFFFFF9, 32'd2, 4'd9);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rdy = 1'b0;
    repeat (5) tick();
    rdy = 1'b1;
    wait_out(60, 1'b0, lat, bad);
    total = (lat < 0) ? -1 : 14 + lat;
    check("freeze_latency", 32'(total), 32'd38);
    check("freeze_data", out_data, 32'hFFFFFFFD);
    check("freeze_tag", {28'b0, out_rob_id}, 32'd9);
    tick();

    // Non-M opcode is ignored.
    drive(OPNUM_ANDI, 32'd1, 32'd2, 4'd4);
    tick();
    in_valid = 1'b0;
    check("nonm_ready", {31'b0, in_ready}, 32'd1);
    count_out(10, hits);
    check("nonm_no_output", 32'(hits), 32'd0);

    // Synchronous reset in the middle of a multiply and a divide.
    drive(OPNUM_MUL, 32'd9, 32'd9, 4'd7);
    tick();
    drive(OPNUM_DIVU, 32'd100, 32'd7, 4'd8);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    count_out(40, hits);
    check("midrst_no_output", 32'(hits), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
